// File: rtl/cpack_pkg.sv
// Shared types and constants for the Stage-3 compression controller:
// code encodings, code lengths, dictionary index width and FSM states.
package cpack_pkg;

    localparam int DICT_IDX_W = 4;
    localparam int CODE_LEN_W = 6;

    localparam logic [CODE_LEN_W-1:0] LEN_ZZZZ = 6'd2;
    localparam logic [CODE_LEN_W-1:0] LEN_MMMM = 6'd6;
    localparam logic [CODE_LEN_W-1:0] LEN_ZZZX = 6'd12;
    localparam logic [CODE_LEN_W-1:0] LEN_MMMX = 6'd16;
    localparam logic [CODE_LEN_W-1:0] LEN_MMXX = 6'd24;
    localparam logic [CODE_LEN_W-1:0] LEN_XXXX = 6'd34;

    typedef enum logic [2:0] {
        CODE_ZZZZ = 3'b000,
        CODE_MMMM = 3'b001,
        CODE_ZZZX = 3'b010,
        CODE_MMMX = 3'b011,
        CODE_MMXX = 3'b100,
        CODE_XXXX = 3'b101
    } code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    function automatic logic [CODE_LEN_W-1:0] code_len(input code_e code);
        case (code)
            CODE_ZZZZ: code_len = LEN_ZZZZ;
            CODE_MMMM: code_len = LEN_MMMM;
            CODE_ZZZX: code_len = LEN_ZZZX;
            CODE_MMMX: code_len = LEN_MMMX;
            CODE_MMXX: code_len = LEN_MMXX;
            default:   code_len = LEN_XXXX;
        endcase
    endfunction

    // Exact and all-zero words are fully described by their code, so they are not learned.
    function automatic logic code_pushes(input code_e code);
        code_pushes = !((code == CODE_ZZZZ) || (code == CODE_MMMM));
    endfunction

endpackage

// File: rtl/cpack_dict_match.sv
// Parallel dictionary comparator: full / upper-24 / upper-16 hit flags,
// each with the lowest matching index.
module cpack_dict_match
    import cpack_pkg::*;
#(
    parameter int DICT_DEPTH = 16
) (
    input  logic [31:0]               i_word,
    input  logic [32*DICT_DEPTH-1:0]  i_dict,
    input  logic [DICT_DEPTH-1:0]     i_valid,
    output logic                      o_full_hit,
    output logic                      o_hi24_hit,
    output logic                      o_hi16_hit,
    output logic [DICT_IDX_W-1:0]     o_full_idx,
    output logic [DICT_IDX_W-1:0]     o_hi24_idx,
    output logic [DICT_IDX_W-1:0]     o_hi16_idx
);

    logic [DICT_DEPTH-1:0] full_vec;
    logic [DICT_DEPTH-1:0] hi24_vec;
    logic [DICT_DEPTH-1:0] hi16_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DICT_DEPTH; gi++) begin : g_cmp
            assign full_vec[gi] = i_valid[gi] && (i_dict[gi*32 +: 32] == i_word);
            assign hi24_vec[gi] = i_valid[gi] && (i_dict[gi*32+8 +: 24] == i_word[31:8]);
            assign hi16_vec[gi] = i_valid[gi] && (i_dict[gi*32+16 +: 16] == i_word[31:16]);
        end
    endgenerate

    // Scanning downward leaves the lowest set index as the final result.
    function automatic logic [DICT_IDX_W-1:0] lowest_idx(input logic [DICT_DEPTH-1:0] vec);
        lowest_idx = '0;
        for (int i = DICT_DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_idx = DICT_IDX_W'(i);
            end
        end
    endfunction

    assign o_full_hit = |full_vec;
    assign o_hi24_hit = |hi24_vec;
    assign o_hi16_hit = |hi16_vec;
    assign o_full_idx = lowest_idx(full_vec);
    assign o_hi24_idx = lowest_idx(hi24_vec);
    assign o_hi16_idx = lowest_idx(hi16_vec);

endmodule

// File: rtl/cpack_compress_ctrl.sv
// Stage-3 compression sequencer: accepts a word, classifies it against a
// 16-entry FIFO-replacement dictionary and holds the result until the packer takes it.
module cpack_compress_ctrl
    import cpack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DICT_DEPTH = 16,
    parameter int TOTAL_BITS = 34,
    localparam int LEN_W     = $clog2(TOTAL_BITS + 1)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_clear,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [DATA_WIDTH-1:0]            i_word,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [2:0]                       o_code,
    output logic [DICT_IDX_W-1:0]            o_dict_idx,
    output logic [DATA_WIDTH-1:0]            o_word,
    output logic [LEN_W-1:0]                 o_code_len,
    output logic [DATA_WIDTH*DICT_DEPTH-1:0] o_dict
);

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    code_e                   code_q, code_d;
    logic [DICT_IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [DATA_WIDTH-1:0]   dict_q [DICT_DEPTH];
    logic [DATA_WIDTH-1:0]   dict_d [DICT_DEPTH];
    logic [DICT_DEPTH-1:0]   vld_q, vld_d;
    logic [DICT_IDX_W-1:0]   wr_ptr_q, wr_ptr_d;

    logic [DATA_WIDTH*DICT_DEPTH-1:0] dict_flat;
    logic                    full_hit, hi24_hit, hi16_hit;
    logic [DICT_IDX_W-1:0]   full_idx, hi24_idx, hi16_idx;
    code_e                   class_code;
    logic [DICT_IDX_W-1:0]   class_idx;

    genvar gi;
    generate
        for (gi = 0; gi < DICT_DEPTH; gi++) begin : g_flat
            assign dict_flat[gi*DATA_WIDTH +: DATA_WIDTH] = dict_q[gi];
        end
    endgenerate

    cpack_dict_match #(
        .DICT_DEPTH (DICT_DEPTH)
    ) u_match (
        .i_word     (word_q[31:0]),
        .i_dict     (dict_flat),
        .i_valid    (vld_q),
        .o_full_hit (full_hit),
        .o_hi24_hit (hi24_hit),
        .o_hi16_hit (hi16_hit),
        .o_full_idx (full_idx),
        .o_hi24_idx (hi24_idx),
        .o_hi16_idx (hi16_idx)
    );

    // Classification priority: first matching rule wins.
    always_comb begin
        class_code = CODE_XXXX;
        class_idx  = '0;
        if (word_q == '0) begin
            class_code = CODE_ZZZZ;
        end else if (full_hit) begin
            class_code = CODE_MMMM;
            class_idx  = full_idx;
        end else if (word_q[31:8] == 24'd0) begin
            class_code = CODE_ZZZX;
        end else if (hi24_hit) begin
            class_code = CODE_MMMX;
            class_idx  = hi24_idx;
        end else if (hi16_hit) begin
            class_code = CODE_MMXX;
            class_idx  = hi16_idx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            word_q   <= '0;
            code_q   <= CODE_ZZZZ;
            idx_q    <= '0;
            len_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DICT_DEPTH; i++) begin
                dict_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            word_q   <= word_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            for (int i = 0; i < DICT_DEPTH; i++) begin
                dict_q[i] <= dict_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (i_valid) state_d = ST_MATCH;
                ST_MATCH: state_d = ST_EMIT;
                ST_EMIT:  if (i_ready) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake flags are registered from the next state so no input reaches them combinationally.
    always_comb begin
        ready_d  = (state_d == ST_IDLE);
        valid_d  = (state_d == ST_EMIT);
        word_d   = word_q;
        code_d   = code_q;
        idx_d    = idx_q;
        len_d    = len_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < DICT_DEPTH; i++) begin
            dict_d[i] = dict_q[i];
        end

        if (i_clear) begin
            vld_d    = '0;
            wr_ptr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) word_d = i_word;
                end
                ST_MATCH: begin
                    code_d = class_code;
                    idx_d  = class_idx;
                    len_d  = LEN_W'(code_len(class_code));
                end
                ST_EMIT: begin
                    if (i_ready && code_pushes(code_q)) begin
                        dict_d[wr_ptr_q] = word_q;
                        vld_d[wr_ptr_q]  = 1'b1;
                        wr_ptr_d = (wr_ptr_q == DICT_IDX_W'(DICT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_word     = word_q;
    assign o_code     = code_q;
    assign o_dict_idx = idx_q;
    assign o_code_len = len_q;
    assign o_dict     = dict_flat;

endmodule
